// File: rtl/sm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : sm_boot_loader
// Purpose  : Holds the schoolMIPS CPU in reset, streams a program into
//            instruction memory over a valid/ready link, then releases the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module sm_boot_loader #(
  parameter int ADDR_WIDTH     = 6,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run_req,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_LOAD    = 3'd1;
  localparam logic [2:0] C_ST_RELEASE = 3'd2;
  localparam logic [2:0] C_ST_RUN     = 3'd3;
  localparam logic [2:0] C_ST_ERROR   = 3'd4;

  localparam logic [3:0] C_REL_INIT = 4'(RELEASE_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [3:0]          rel_q, rel_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= C_ST_IDLE;
      cnt_q       <= '0;
      rel_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign w_accept = ld_valid & ld_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    case (state_q)
      C_ST_IDLE: begin
        if (start) begin
          state_d = C_ST_LOAD;
          cnt_d   = '0;
        end else if (run_req) begin
          state_d = C_ST_RELEASE;
          rel_d   = C_REL_INIT;
        end
      end
      C_ST_LOAD: begin
        if (w_accept) begin
          // The top bit of cnt set means every address is already written.
          if (cnt_q[ADDR_WIDTH]) begin
            state_d = C_ST_ERROR;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (ld_last) begin
              state_d = C_ST_RELEASE;
              rel_d   = C_REL_INIT;
            end
          end
        end
      end
      C_ST_RELEASE: begin
        if (rel_q == 4'd0) state_d = C_ST_RUN;
        else               rel_d   = rel_q - 1'b1;
      end
      C_ST_RUN, C_ST_ERROR: begin
        if (start) begin
          state_d = C_ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // Registered flags are computed from the next state so they change together
  // with the state register.
  always_comb begin
    ld_ready    = (state_q == C_ST_LOAD);
    mem_we      = ld_ready & ld_valid & ~cnt_q[ADDR_WIDTH];
    mem_addr    = cnt_q[ADDR_WIDTH-1:0];
    mem_wdata   = ld_data;
    busy        = (state_q == C_ST_LOAD) | (state_q == C_ST_RELEASE);
    cpu_rst_n_d = (state_d == C_ST_RUN);
    done_d      = (state_d == C_ST_RUN) & (state_q != C_ST_RUN);
    error_d     = (state_d == C_ST_ERROR);
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_boot_loader
// Purpose  : Randomized self-checking bench for sm_boot_loader (AW=4, RC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_boot_loader;

  localparam int AW    = 4;
  localparam int RC    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          run_req = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  sm_boot_loader #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .run_req(run_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Monitor: owns everything it records; the stimulus side only reads.
  int          writes = 0;
  int          bad_wr = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_cyc = 0;
  logic        rstn_at_done = 1'b0;
  logic        rstn_before_done = 1'b0;
  logic        prev_rstn = 1'b0;
  int          wr_addr[$];
  int          wr_cyc[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (mem_we) begin
      writes++;
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
      if (!(ld_valid && ld_ready)) bad_wr++;
    end
    if (ld_valid && ld_ready && ld_last) last_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc         = cyc;
      rstn_at_done     = cpu_rst_n;
      rstn_before_done = prev_rstn;
    end
    prev_rstn = cpu_rst_n;
  end

  logic [31:0] stim [DEPTH+1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check_eq({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int base_d);
    for (int t = 0; t < 20 && done_cnt == base_d; t++) @(posedge clk);
    #1;
    check_eq("done_seen", 32'(done_cnt != base_d), 32'd1);
  endtask

  // One load session: start pulse, n words, optional ld_last on the final one.
  task automatic session(input int n, input bit use_last, input int gap_pct, input bit rand_data);
    int base_w, base_d, base_q, exp_w;
    bit ovf;
    base_w = writes;
    base_d = done_cnt;
    base_q = wr_addr.size();
    if (rand_data) for (int i = 0; i < n; i++) stim[i] = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("start_error", 32'(error), 32'd0);
    check_eq("start_word_count", 32'(word_count), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        ld_valid = 1'b0;
        @(posedge clk); #1;
      end
      ld_valid = 1'b1;
      ld_data  = stim[i];
      ld_last  = use_last && (i == n - 1);
      @(negedge clk);
      check_eq("word_ld_ready", 32'(ld_ready), 32'd1);
      check_eq("word_mem_we", 32'(mem_we), 32'(i < DEPTH));
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ovf   = (n > DEPTH);
    exp_w = ovf ? DEPTH : n;
    check_eq("write_count", 32'(writes - base_w), 32'(exp_w));
    for (int i = 0; i < exp_w && base_q + i < wr_addr.size(); i++) begin
      check_eq("write_addr", 32'(wr_addr[base_q+i]), 32'(i));
      check_eq("write_data", wr_data[base_q+i], stim[i]);
      if (gap_pct == 0 && i > 0)
        check_eq("write_b2b", 32'(wr_cyc[base_q+i] - wr_cyc[base_q+i-1]), 32'd1);
    end
    if (ovf) begin
      check_eq("ovf_error", 32'(error), 32'd1);
      check_eq("ovf_ld_ready", 32'(ld_ready), 32'd0);
      check_eq("ovf_busy", 32'(busy), 32'd0);
      check_eq("ovf_word_count", 32'(word_count), 32'(DEPTH));
      repeat (3) @(posedge clk);
      #1;
      check_eq("ovf_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_eq("ovf_no_done", 32'(done_cnt - base_d), 32'd0);
    end else if (use_last) begin
      wait_done(base_d);
      check_eq("release_latency", 32'(done_cyc - last_cyc), 32'(RC + 1));
      check_eq("rstn_with_done", 32'(rstn_at_done), 32'd1);
      check_eq("rstn_before_done", 32'(rstn_before_done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_single", 32'(done_cnt - base_d), 32'd1);
      check_eq("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      check_eq("run_word_count", 32'(word_count), 32'(n));
      check_eq("run_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, bd, bw;
    #1;
    do_reset();

    stim[0] = 32'h24080001;
    stim[1] = 32'h24090002;
    stim[2] = 32'h1000FFFF;
    session(3, 1'b1, 0, 1'b0);

    session(4, 1'b1, 100, 1'b1);
    session(17, 1'b0, 0, 1'b1);
    session(5, 1'b1, 0, 1'b1);
    session(16, 1'b1, 0, 1'b1);

    // run_req is ignored in RUN
    bd = done_cnt;
    run_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_req = 1'b0;
    check_eq("run_req_in_run_done", 32'(done_cnt - bd), 32'd0);
    check_eq("run_req_in_run_rstn", 32'(cpu_rst_n), 32'd1);

    // start and run_req together: start wins
    do_reset();
    start = 1'b1;
    run_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_req = 1'b0;
    check_eq("both_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("both_busy", 32'(busy), 32'd1);
    session(2, 1'b1, 0, 1'b1);

    // run_req alone releases without writing
    do_reset();
    bd = done_cnt;
    bw = writes;
    c0 = cyc;
    run_req = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b0;
    check_eq("runreq_busy", 32'(busy), 32'd1);
    check_eq("runreq_ld_ready", 32'(ld_ready), 32'd0);
    wait_done(bd);
    check_eq("runreq_latency", 32'(done_cyc - c0), 32'(RC + 1));
    check_eq("runreq_writes", 32'(writes - bw), 32'd0);
    check_eq("runreq_word_count", 32'(word_count), 32'd0);
    check_eq("runreq_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    // asynchronous reset in the middle of a load
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
      @(posedge clk); #1;
    end
    check_eq("midload_word_count", 32'(word_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    ld_valid = 1'b0;
    session(5, 1'b1, 0, 1'b1);

    for (int k = 0; k < 6; k++)
      session(int'($urandom_range(16, 1)), 1'b1, int'($urandom_range(50, 0)), 1'b1);

    check_eq("stray_writes", 32'(bad_wr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_boot_loader.md
# sm_boot_loader

Boot sequencer for the schoolMIPS core. It holds the CPU in reset, streams a program into instruction memory through a valid/ready word interface, then releases the CPU after a fixed settle delay. It sits between the host/UART link, the instruction-memory write port and the CPU's active-low `rst_n`. It also supports re-loading from RUN and releasing the CPU without loading.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: instruction-memory word address width; DEPTH = 2**ADDR_WIDTH words.
- `RELEASE_CYCLES`, default 2: number of cycles the CPU is held in reset after the last word is written. Legal range is 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a load session; sampled in IDLE, RUN and ERROR.
- `run_req`  in  1  release the CPU with the current memory contents; sampled in IDLE only.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final word of the session; qualified by `ld_valid & ld_ready`.
- `ld_ready`  out  1  loader accepts a word.
- `mem_we`  out  1  instruction-memory write enable.
- `mem_addr`  out  ADDR_WIDTH  instruction-memory word address.
- `mem_wdata`  out  32  instruction-memory write data.
- `cpu_rst_n`  out  1  CPU reset, active-low, registered.
- `busy`  out  1  high in LOAD or RELEASE.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `error`  out  1  high in ERROR.
- `word_count`  out  ADDR_WIDTH+1  number of words written in the current or last session.

## Operation
- FSM states: IDLE, LOAD, RELEASE, RUN, ERROR. The reset state is IDLE.
- Reset values: `cpu_rst_n`=0, `ld_ready`=0, `mem_we`=0, `mem_addr`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0. The address counter and release counter reset to 0.
- Address counter `cnt` is ADDR_WIDTH+1 bits wide. `mem_addr` = `cnt[ADDR_WIDTH-1:0]`. `word_count` = `cnt`.
- IDLE:
  - `start` → LOAD.
  - Otherwise `run_req` → RELEASE. `start` wins when both are high.
- Entering LOAD clears `cnt` to 0.
- LOAD:
  - `ld_ready`=1. A word is accepted when `ld_valid & ld_ready`.
  - Accepted word with `cnt` < DEPTH: `mem_we`=1, `mem_wdata`=`ld_data`, and `cnt` increments.
  - Accepted word with `ld_last`=1 → RELEASE. The word is written first.
  - Accepted word with `cnt`==DEPTH (overflow): `mem_we`=0, the word is discarded, → ERROR.
  - A word written at address DEPTH-1 with `ld_last`=1 is legal.
- RELEASE: the release counter loads RELEASE_CYCLES-1 on entry and decrements each cycle. At 0 → RUN.
- RUN: `cpu_rst_n`=1. `start` → LOAD; `run_req` is ignored.
- ERROR: the CPU is held in reset and `error`=1. `start` → LOAD, which clears `error` and `cnt`.
- `start` and `run_req` are ignored in LOAD and RELEASE.
- `mem_we`, `ld_ready`, `mem_addr` and `mem_wdata` are combinational decodes of state, `cnt` and inputs. `mem_we` never asserts outside LOAD.
- `cpu_rst_n`, `done` and `error` are registered. They take their new value in the same cycle the FSM enters the new state.

## Timing
- `start` high in RUN at edge N: LOAD and `cpu_rst_n`=0 from edge N. `ld_ready`=1 in the cycle after edge N.
- The write for a word accepted in cycle k occurs in cycle k; `mem_addr` increments at the end of cycle k.
- Last word accepted in cycle k: RELEASE spans cycles k+1 .. k+RELEASE_CYCLES. RUN, `cpu_rst_n`=1 and `done`=1 start in cycle k+RELEASE_CYCLES+1.
- `done` is exactly one cycle per RUN entry.
- Back-to-back words are accepted every cycle; the sustained rate is 1 word/cycle.
- `ld_valid` low in LOAD: the FSM waits indefinitely, with no timeout.
- Asynchronous `rst` at any time (including mid-LOAD or RELEASE): immediately IDLE with all outputs at their reset values. Memory already written is not scrubbed.
- `word_count` holds its final value through RELEASE, RUN and ERROR until the next LOAD entry.

## Test plan
Bench configuration: ADDR_WIDTH=4, RELEASE_CYCLES=2.
- Reset, then `start`, then 3 back-to-back words 0x24080001, 0x24090002, 0x1000FFFF (`ld_last` on the third) → writes at addresses 0,1,2 in consecutive cycles. `cpu_rst_n` rises exactly 3 cycles after the last accept, with a coincident single-cycle `done`. `word_count`=3.
- `ld_valid` toggling 1,0,1,0 with 4 words → only 4 writes, at addresses 0..3. No write in idle cycles. `word_count`=4.
- 17 words with no `ld_last` → 16 writes (addresses 0..15). The 17th is accepted with `mem_we`=0 and `error`=1 next cycle. `cpu_rst_n` stays 0. Then `start` → `error`=0 and `word_count`=0.
- 16 words with `ld_last` on the 16th (address 15) → no error. RUN is reached and `word_count`=16.
- `start` and `run_req` high together in IDLE → LOAD entered. Separately, `run_req` alone in IDLE → RUN after 2 release cycles with zero writes.
- `rst` asserted after 2 of 5 words → IDLE, `cpu_rst_n`=0, `ld_ready`=0, `word_count`=0 immediately. A new `start` reloads from address 0.
